// File: rtl/scr1_tcm_sp_arb_pkg.sv
// ---------------------------------------------------------------------------
// scr1_tcm_sp_arb_pkg
// Purpose : Memory-interface types shared by the TCM single-port arbiter,
//           its round-robin sub-block and anything that talks to them.
//           Command / width / response enums are the common memif
//           encodings. Every other file imports them from here.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package scr1_tcm_sp_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Requester index inside the two-way arbiter (req[0] = imem, req[1] = dmem).
  localparam logic SCR1_ARB_IMEM = 1'b0;
  localparam logic SCR1_ARB_DMEM = 1'b1;

  // Per-port state captured at grant and consumed in the response cycle.
  typedef struct packed {
    logic       pend;  // a grant happened last cycle
    logic       err;   // that access was rejected (range / alignment)
    logic [1:0] off;   // byte offset used to align returned read data
  } type_scr1_tcm_rsp_s;

endpackage

// File: rtl/scr1_tcm_sp_arb_if.sv
// ---------------------------------------------------------------------------
// scr1_tcm_sp_arb_if
// Purpose : Bundles the instruction port, data port and external SRAM port
//           of the TCM arbiter.
// Modports: slave  - the arbiter (takes imem/dmem requests, drives SRAM)
//           master - the environment (cores + SRAM model)
// Handshake: a port presents req with its address/command; the request is
//           taken in any cycle where req_ack=1 (combinational, same cycle).
//           A port that sees req=1 and req_ack=0 must keep req and its
//           payload stable. Exactly one cycle after the ack, resp shows
//           RDY_OK or RDY_ER (rdata valid only in that cycle); resp is
//           NOTRDY in every other cycle. SRAM read data (mem_rdata) is
//           valid one cycle after mem_req.
// ---------------------------------------------------------------------------
interface scr1_tcm_sp_arb_if #(
  parameter int unsigned SCR1_MEM_AW = 14
) ();
  import scr1_tcm_sp_arb_pkg::*;

  // instruction port
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_req_ack;
  logic [31:0]          imem_rdata;
  type_scr1_mem_resp_e  imem_resp;

  // data port
  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  // external SRAM port
  logic                   mem_req;
  logic                   mem_wen;
  logic [SCR1_MEM_AW-1:0] mem_addr;
  logic [3:0]             mem_byteen;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  modport slave (
    input  imem_req, imem_addr,
    output imem_req_ack, imem_rdata, imem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp,
    output mem_req, mem_wen, mem_addr, mem_byteen, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output imem_req, imem_addr,
    input  imem_req_ack, imem_rdata, imem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    input  mem_req, mem_wen, mem_addr, mem_byteen, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/scr1_tcm_sp_arb_rr_arb2.sv
// ---------------------------------------------------------------------------
// scr1_rr_arb2
// Purpose : Two-way round-robin arbiter. A lone requester wins at once; on
//           a conflict the requester that did not win last time wins.
//           The last-grant register only moves when something is granted.
// Ports   : clk, rst     - clock, async active-high reset
//           req_i[1:0]   - request vector (bit 0 = imem, bit 1 = dmem)
//           gnt_o[1:0]   - one-hot (or zero) combinational grant
//           last_gnt_o   - index of the most recent winner (debug/state)
// ---------------------------------------------------------------------------
module scr1_rr_arb2
  import scr1_tcm_sp_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       last_gnt_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Conflict: hand the grant to whichever side lost last time.
      2'b11:   gnt_o = (last_gnt_q == SCR1_ARB_DMEM) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_o[1])      last_gnt_d = SCR1_ARB_DMEM;
    else if (gnt_o[0]) last_gnt_d = SCR1_ARB_IMEM;
  end

  // Reset to IMEM so that dmem wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_gnt_q <= SCR1_ARB_IMEM;
    else     last_gnt_q <= last_gnt_d;
  end

  assign last_gnt_o = last_gnt_q;

endmodule

// File: rtl/scr1_tcm_sp_arb.sv
// ---------------------------------------------------------------------------
// scr1_tcm_sp_arb
// Purpose : Shares one external single-port TCM SRAM between the
//           instruction and data ports. One access per cycle, round-robin
//           on conflict, response exactly one cycle after the grant.
//           Out-of-range or misaligned accesses are acked but never reach
//           the SRAM; they answer RDY_ER with zero data.
// Ports   : clk, rst        - clock, async active-high reset
//           bus (slave)     - imem / dmem request ports and SRAM port
//           dbg_last_gnt_o  - last-grant state (0 = imem, 1 = dmem)
// ---------------------------------------------------------------------------
module scr1_tcm_sp_arb
  import scr1_tcm_sp_arb_pkg::*;
#(
  parameter int unsigned SCR1_TCM_SIZE = 32'h00010000,
  parameter int unsigned SCR1_MEM_AW   = $clog2(SCR1_TCM_SIZE) - 2
) (
  input  logic             clk,
  input  logic             rst,
  scr1_tcm_sp_arb_if.slave bus,
  output logic             dbg_last_gnt_o
);

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       imem_err;
  logic       dmem_err;
  logic       dmem_mis;
  logic       imem_go;
  logic       dmem_go;

  type_scr1_tcm_rsp_s imem_rsp_q, imem_rsp_d;
  type_scr1_tcm_rsp_s dmem_rsp_q, dmem_rsp_d;

  assign arb_req = {bus.dmem_req, bus.imem_req};

  scr1_rr_arb2 i_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req_i      (arb_req),
    .gnt_o      (arb_gnt),
    .last_gnt_o (dbg_last_gnt_o)
  );

  // Acks are the grant itself, even while reset is held.
  assign bus.imem_req_ack = arb_gnt[0];
  assign bus.dmem_req_ack = arb_gnt[1];

  // imem is always a word read: only word alignment matters.
  assign imem_err = (bus.imem_addr >= SCR1_TCM_SIZE) | (bus.imem_addr[1:0] != 2'b00);

  always_comb begin
    dmem_mis = 1'b0;
    case (bus.dmem_width)
      SCR1_MEM_WIDTH_BYTE:  dmem_mis = 1'b0;
      SCR1_MEM_WIDTH_HWORD: dmem_mis = bus.dmem_addr[0];
      SCR1_MEM_WIDTH_WORD:  dmem_mis = (bus.dmem_addr[1:0] != 2'b00);
      default:              dmem_mis = 1'b1;
    endcase
  end

  assign dmem_err = (bus.dmem_addr >= SCR1_TCM_SIZE) | dmem_mis;

  assign imem_go = arb_gnt[0] & ~imem_err;
  assign dmem_go = arb_gnt[1] & ~dmem_err;

  // SRAM strobes are suppressed during reset even though acks are not.
  assign bus.mem_req  = ~rst & (imem_go | dmem_go);
  assign bus.mem_wen  = ~rst & dmem_go & (bus.dmem_cmd == SCR1_MEM_CMD_WR);
  assign bus.mem_addr = arb_gnt[1] ? bus.dmem_addr[SCR1_MEM_AW+1:2]
                                   : bus.imem_addr[SCR1_MEM_AW+1:2];

  // Sub-word writes replicate the lane so the byte enables pick it out.
  always_comb begin
    bus.mem_byteen = 4'b1111;
    bus.mem_wdata  = bus.dmem_wdata;
    if (arb_gnt[1]) begin
      case (bus.dmem_width)
        SCR1_MEM_WIDTH_BYTE: begin
          bus.mem_byteen = 4'b0001 << bus.dmem_addr[1:0];
          bus.mem_wdata  = {4{bus.dmem_wdata[7:0]}};
        end
        SCR1_MEM_WIDTH_HWORD: begin
          bus.mem_byteen = 4'b0011 << {bus.dmem_addr[1], 1'b0};
          bus.mem_wdata  = {2{bus.dmem_wdata[15:0]}};
        end
        default: begin
          bus.mem_byteen = 4'b1111;
          bus.mem_wdata  = bus.dmem_wdata;
        end
      endcase
    end
  end

  // Capture what the response cycle needs: was there a grant, did it fail,
  // and which byte lane the read data must be shifted down from.
  always_comb begin
    imem_rsp_d      = '0;
    imem_rsp_d.pend = arb_gnt[0];
    imem_rsp_d.err  = imem_err;
    imem_rsp_d.off  = bus.imem_addr[1:0];
    dmem_rsp_d      = '0;
    dmem_rsp_d.pend = arb_gnt[1];
    dmem_rsp_d.err  = dmem_err;
    dmem_rsp_d.off  = bus.dmem_addr[1:0];
  end

  // Asynchronous reset drops any pending response on the spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rsp_q <= '0;
      dmem_rsp_q <= '0;
    end else begin
      imem_rsp_q <= imem_rsp_d;
      dmem_rsp_q <= dmem_rsp_d;
    end
  end

  always_comb begin
    bus.imem_resp  = SCR1_MEM_RESP_NOTRDY;
    bus.imem_rdata = '0;
    if (imem_rsp_q.pend) begin
      if (imem_rsp_q.err) begin
        bus.imem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        bus.imem_resp  = SCR1_MEM_RESP_RDY_OK;
        bus.imem_rdata = bus.mem_rdata >> {imem_rsp_q.off, 3'b000};
      end
    end
  end

  always_comb begin
    bus.dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    bus.dmem_rdata = '0;
    if (dmem_rsp_q.pend) begin
      if (dmem_rsp_q.err) begin
        bus.dmem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        bus.dmem_resp  = SCR1_MEM_RESP_RDY_OK;
        bus.dmem_rdata = bus.mem_rdata >> {dmem_rsp_q.off, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_scr1_tcm_sp_arb.sv
// ---------------------------------------------------------------------------
// tb_scr1_tcm_sp_arb
// Directed scenarios followed by randomized traffic. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge. The random phase predicts grants, SRAM strobes and the
// one-cycle-late responses from the arbitration and alignment rules.
// ---------------------------------------------------------------------------
module tb_scr1_tcm_sp_arb;
  import scr1_tcm_sp_arb_pkg::*;

  localparam int unsigned TCM_SIZE = 32'h00010000;
  localparam int unsigned MEM_AW   = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_last_gnt;
  always #5 clk = ~clk;

  scr1_tcm_sp_arb_if #(.SCR1_MEM_AW(MEM_AW)) bus ();

  scr1_tcm_sp_arb #(
    .SCR1_TCM_SIZE (TCM_SIZE),
    .SCR1_MEM_AW   (MEM_AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .dbg_last_gnt_o (dbg_last_gnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // rdata is only meaningful when a response is shown; RDY_ER must carry zero.
  task automatic check_resp(input string tag, input logic [1:0] obs_resp, input logic [31:0] obs_rdata,
                            input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    check({tag, "_resp"}, 32'(obs_resp), 32'(exp_resp));
    if (exp_resp != SCR1_MEM_RESP_NOTRDY) check({tag, "_rdata"}, obs_rdata, exp_rdata);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_begin(input logic [31:0] rdata);
    @(negedge clk);
    bus.mem_rdata = rdata;
  endtask

  task automatic drive_i(input logic req, input logic [31:0] addr);
    bus.imem_req  = req;
    bus.imem_addr = addr;
  endtask

  task automatic drive_d(input logic req, input logic wr, input logic [1:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.dmem_req   = req;
    bus.dmem_cmd   = type_scr1_mem_cmd_e'(wr);
    bus.dmem_width = type_scr1_mem_width_e'(width);
    bus.dmem_addr  = addr;
    bus.dmem_wdata = wdata;
  endtask

  task automatic idle();
    drive_i(1'b0, 32'h0);
    drive_d(1'b0, 1'b0, SCR1_MEM_WIDTH_BYTE, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if (k < 7)      a = 32'($urandom_range(0, TCM_SIZE - 1));
    else if (k < 9) a = TCM_SIZE + 32'($urandom_range(0, 255));
    else            a = $urandom();
    return a;
  endfunction

  // ---------------- reference model state ----------------
  logic [3:0]  exp_i_q[$];   // {resp, byte offset} expected next cycle
  logic [3:0]  exp_d_q[$];
  logic        m_last_d;     // 1 when dmem was the most recent winner
  logic        i_req_m, d_req_m, d_wr_m, i_hold, d_hold, gi, gd, i_ok, d_ok, exp_mreq, exp_wen;
  logic [1:0]  d_width_m;
  logic [31:0] i_addr_m, d_addr_m, d_wdata_m, rd, e_rdata, e_wdata;
  logic [3:0]  e, e_ben;
  int          i_wait, d_wait;

  initial begin
    rst = 1'b1;
    idle();
    bus.mem_rdata = 32'h0;

    // ---- reset state ----
    cyc_begin(32'h0);
    #1;
    check("rst_i_resp", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_d_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rst_i_rdata", bus.imem_rdata, 32'h0);
    check("rst_d_rdata", bus.dmem_rdata, 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_last_gnt", 32'(dbg_last_gnt), 32'h0);

    // Acks still follow the grant in reset, but nothing reaches the SRAM.
    cyc_begin($urandom());
    drive_i(1'b1, 32'h100);
    drive_d(1'b1, 1'b1, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h11223344);
    #1;
    check("rst_d_ack", 32'(bus.dmem_req_ack), 32'h1);
    check("rst_i_ack", 32'(bus.imem_req_ack), 32'h0);
    check("rst_mem_req2", 32'(bus.mem_req), 32'h0);
    check("rst_mem_wen", 32'(bus.mem_wen), 32'h0);

    cyc_begin($urandom());
    idle();
    rst = 1'b0;
    #1;
    check("rel_i_resp", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rel_d_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

    // ---- imem read, addr 0x100 ----
    cyc_begin($urandom());
    drive_i(1'b1, 32'h100);
    #1;
    check("i100_ack", 32'(bus.imem_req_ack), 32'h1);
    check("i100_d_ack", 32'(bus.dmem_req_ack), 32'h0);
    check("i100_mem_req", 32'(bus.mem_req), 32'h1);
    check("i100_mem_wen", 32'(bus.mem_wen), 32'h0);
    check("i100_mem_addr", 32'(bus.mem_addr), 32'h40);
    cyc_begin(32'hDEADBEEF);
    idle();
    #1;
    check_resp("i100", bus.imem_resp, bus.imem_rdata, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
    check("i100_d_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    cyc_begin($urandom());
    #1;
    check("i100_resp_once", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

    // ---- dmem byte write 0xA5 to 0x7 ----
    cyc_begin($urandom());
    drive_d(1'b1, 1'b1, SCR1_MEM_WIDTH_BYTE, 32'h7, 32'h000000A5);
    #1;
    check("bw_ack", 32'(bus.dmem_req_ack), 32'h1);
    check("bw_mem_req", 32'(bus.mem_req), 32'h1);
    check("bw_mem_wen", 32'(bus.mem_wen), 32'h1);
    check("bw_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    check("bw_byteen", 32'(bus.mem_byteen), 32'h8);
    check("bw_mem_addr", 32'(bus.mem_addr), 32'h1);
    cyc_begin($urandom());
    idle();
    #1;
    check("bw_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));

    // ---- dmem halfword read 0x2 ----
    cyc_begin($urandom());
    drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_HWORD, 32'h2, 32'h0);
    #1;
    check("hr_mem_req", 32'(bus.mem_req), 32'h1);
    check("hr_mem_wen", 32'(bus.mem_wen), 32'h0);
    check("hr_mem_addr", 32'(bus.mem_addr), 32'h0);
    cyc_begin(32'h12345678);
    idle();
    #1;
    check_resp("hr", bus.dmem_resp, bus.dmem_rdata, SCR1_MEM_RESP_RDY_OK, 32'h00001234);

    // ---- dmem word write to 0x10001: out of range and misaligned ----
    cyc_begin($urandom());
    drive_d(1'b1, 1'b1, SCR1_MEM_WIDTH_WORD, 32'h00010001, 32'hCAFEF00D);
    #1;
    check("oor_ack", 32'(bus.dmem_req_ack), 32'h1);
    check("oor_mem_req", 32'(bus.mem_req), 32'h0);
    check("oor_mem_wen", 32'(bus.mem_wen), 32'h0);
    cyc_begin($urandom());
    idle();
    #1;
    check_resp("oor", bus.dmem_resp, bus.dmem_rdata, SCR1_MEM_RESP_RDY_ER, 32'h0);

    // ---- boundaries: misaligned imem, last in-range word, first out-of-range byte ----
    cyc_begin($urandom());
    drive_i(1'b1, 32'h102);
    #1;
    check("imis_mem_req", 32'(bus.mem_req), 32'h0);
    cyc_begin($urandom());
    drive_i(1'b0, 32'h0);
    drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_WORD, TCM_SIZE - 4, 32'h0);
    #1;
    check_resp("imis", bus.imem_resp, bus.imem_rdata, SCR1_MEM_RESP_RDY_ER, 32'h0);
    check("top_mem_req", 32'(bus.mem_req), 32'h1);
    check("top_mem_addr", 32'(bus.mem_addr), 32'h3FFF);
    rd = $urandom();
    cyc_begin(rd);
    drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_BYTE, TCM_SIZE, 32'h0);
    #1;
    check_resp("top", bus.dmem_resp, bus.dmem_rdata, SCR1_MEM_RESP_RDY_OK, rd);
    check("edge_mem_req", 32'(bus.mem_req), 32'h0);
    cyc_begin($urandom());
    idle();
    #1;
    check_resp("edge", bus.dmem_resp, bus.dmem_rdata, SCR1_MEM_RESP_RDY_ER, 32'h0);

    // ---- reset pulsed the cycle after a dmem grant ----
    cyc_begin($urandom());
    drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0);
    #1;
    check("rp_ack", 32'(bus.dmem_req_ack), 32'h1);
    cyc_begin($urandom());
    idle();
    rst = 1'b1;
    #1;
    check("rp_d_resp_in", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    check("rp_i_resp_in", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    cyc_begin($urandom());
    rst = 1'b0;
    #1;
    check("rp_d_resp_out", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));

    // ---- both ports request continuously: D,I,D,I,... ----
    for (int k = 0; k < 8; k++) begin
      rd = $urandom();
      cyc_begin(rd);
      drive_i(1'b1, 32'h200);
      drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_BYTE, 32'h301, 32'h0);
      #1;
      check("alt_d_ack", 32'(bus.dmem_req_ack), 32'((k % 2) == 0));
      check("alt_i_ack", 32'(bus.imem_req_ack), 32'((k % 2) == 1));
      check("alt_mem_addr", 32'(bus.mem_addr), ((k % 2) == 0) ? 32'hC0 : 32'h80);
      if (k > 0) begin
        check_resp("alt_d", bus.dmem_resp, bus.dmem_rdata,
                   ((k % 2) == 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY, rd >> 8);
        check_resp("alt_i", bus.imem_resp, bus.imem_rdata,
                   ((k % 2) == 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY, rd);
      end
    end
    rd = $urandom();
    cyc_begin(rd);
    idle();
    #1;
    check_resp("alt_i_last", bus.imem_resp, bus.imem_rdata, SCR1_MEM_RESP_RDY_OK, rd);

    // ---- back-to-back dmem byte reads, no bubble ----
    for (int k = 0; k < 5; k++) begin
      rd = $urandom();
      cyc_begin(rd);
      if (k < 4) drive_d(1'b1, 1'b0, SCR1_MEM_WIDTH_BYTE, 32'h40 + 32'(k), 32'h0);
      else       idle();
      #1;
      if (k < 4) check("b2b_ack", 32'(bus.dmem_req_ack), 32'h1);
      if (k > 0) check_resp("b2b", bus.dmem_resp, bus.dmem_rdata, SCR1_MEM_RESP_RDY_OK, rd >> (8 * (k - 1)));
    end

    // ---- randomized traffic against the reference model ----
    m_last_d = 1'b1;
    exp_i_q.push_back({SCR1_MEM_RESP_NOTRDY, 2'b00});
    exp_d_q.push_back({SCR1_MEM_RESP_NOTRDY, 2'b00});
    i_req_m = 1'b0; d_req_m = 1'b0; i_hold = 1'b0; d_hold = 1'b0;
    i_addr_m = 32'h0; d_addr_m = 32'h0; d_wdata_m = 32'h0; d_wr_m = 1'b0;
    d_width_m = SCR1_MEM_WIDTH_BYTE;
    i_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rd = $urandom();
      cyc_begin(rd);
      if (!i_hold) begin
        i_req_m  = ($urandom_range(0, 3) != 0);
        i_addr_m = rand_addr();
        if ($urandom_range(0, 4) != 0) i_addr_m[1:0] = 2'b00;
      end
      if (!d_hold) begin
        d_req_m   = ($urandom_range(0, 3) != 0);
        d_wr_m    = 1'($urandom_range(0, 1));
        d_width_m = 2'($urandom_range(0, 2));
        d_addr_m  = rand_addr();
        d_wdata_m = $urandom();
        if ($urandom_range(0, 2) != 0) begin
          if (d_width_m == SCR1_MEM_WIDTH_HWORD) d_addr_m[0] = 1'b0;
          if (d_width_m == SCR1_MEM_WIDTH_WORD)  d_addr_m[1:0] = 2'b00;
        end
      end
      drive_i(i_req_m, i_addr_m);
      drive_d(d_req_m, d_wr_m, d_width_m, d_addr_m, d_wdata_m);
      #1;
      check("r_last_gnt", 32'(dbg_last_gnt), 32'(m_last_d));

      // Conflict goes to the side that did not win most recently.
      gi = i_req_m && (!d_req_m || m_last_d);
      gd = d_req_m && (!i_req_m || !m_last_d);
      check("r_i_ack", 32'(bus.imem_req_ack), 32'(gi));
      check("r_d_ack", 32'(bus.dmem_req_ack), 32'(gd));

      e = exp_i_q.pop_front();
      check_resp("r_i", bus.imem_resp, bus.imem_rdata, e[3:2],
                 (e[3:2] == SCR1_MEM_RESP_RDY_OK) ? (rd >> (8 * e[1:0])) : 32'h0);
      e = exp_d_q.pop_front();
      check_resp("r_d", bus.dmem_resp, bus.dmem_rdata, e[3:2],
                 (e[3:2] == SCR1_MEM_RESP_RDY_OK) ? (rd >> (8 * e[1:0])) : 32'h0);

      i_ok = (i_addr_m < TCM_SIZE) && ((i_addr_m % 4) == 0);
      d_ok = (d_addr_m < TCM_SIZE)
          && !((d_width_m == SCR1_MEM_WIDTH_HWORD) && ((d_addr_m % 2) != 0))
          && !((d_width_m == SCR1_MEM_WIDTH_WORD)  && ((d_addr_m % 4) != 0));
      exp_mreq = (gi && i_ok) || (gd && d_ok);
      exp_wen  = gd && d_ok && d_wr_m;
      check("r_mem_req", 32'(bus.mem_req), 32'(exp_mreq));
      check("r_mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
      if (exp_mreq) check("r_mem_addr", 32'(bus.mem_addr), (gi ? i_addr_m : d_addr_m) / 4);
      if (exp_wen) begin
        case (d_width_m)
          SCR1_MEM_WIDTH_BYTE: begin
            e_ben   = 4'(1 << (d_addr_m % 4));
            e_wdata = (d_wdata_m % 256) * 32'h01010101;
          end
          SCR1_MEM_WIDTH_HWORD: begin
            e_ben   = 4'(3 << (d_addr_m % 4));
            e_wdata = (d_wdata_m % 65536) * 32'h00010001;
          end
          default: begin
            e_ben   = 4'hF;
            e_wdata = d_wdata_m;
          end
        endcase
        check("r_byteen", 32'(bus.mem_byteen), 32'(e_ben));
        check("r_wdata", bus.mem_wdata, e_wdata);
      end

      exp_i_q.push_back(gi ? {(i_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER), i_addr_m[1:0]}
                           : {SCR1_MEM_RESP_NOTRDY, 2'b00});
      exp_d_q.push_back(gd ? {(d_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER), d_addr_m[1:0]}
                           : {SCR1_MEM_RESP_NOTRDY, 2'b00});
      if (gi)      m_last_d = 1'b0;
      else if (gd) m_last_d = 1'b1;

      // A losing requester holds its request and must win by the next cycle.
      i_hold = i_req_m && !bus.imem_req_ack;
      d_hold = d_req_m && !bus.dmem_req_ack;
      i_wait = i_hold ? i_wait + 1 : 0;
      d_wait = d_hold ? d_wait + 1 : 0;
      if (i_hold) check("r_i_starve", 32'(i_wait <= 1), 32'h1);
      if (d_hold) check("r_d_starve", 32'(d_wait <= 1), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scr1_tcm_sp_arb.md
SCR1_TCM_SP_ARB -- requirements
Module: scr1_tcm_sp_arb

Interface
REQ-001 SHALL have parameter SCR1_TCM_SIZE, default 32'h00010000, TCM size in bytes, power of two.
REQ-002 SHALL have parameter SCR1_MEM_AW, default $clog2(SCR1_TCM_SIZE)-2, SRAM word-address width.
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 imem_req  in  1  instruction read request.
REQ-006 imem_addr  in  32  instruction byte address.
REQ-007 imem_req_ack  out  1  imem request accepted this cycle.
REQ-008 imem_rdata  out  32  instruction read data.
REQ-009 imem_resp  out  2  type_scr1_mem_resp_e response.
REQ-010 dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata  in  1/1/2/32/32  data request, command, width, byte address, write data.
REQ-011 dmem_req_ack  out  1;  dmem_rdata  out  32;  dmem_resp  out  2  (same semantics as imem).
REQ-012 mem_req, mem_wen  out  1/1  SRAM access strobe and write enable.
REQ-013 mem_addr  out  SCR1_MEM_AW  word address;  mem_byteen  out  4;  mem_wdata  out  32;  mem_rdata  in  32 (valid one cycle after mem_req).

Function
REQ-014 SHALL grant at most one requester per cycle; imem_req_ack and dmem_req_ack are combinational and equal to the grant.
REQ-015 Single requester -> granted the same cycle; both requesting -> grant goes to the port not granted last (round-robin); a last_gnt register updates only on a grant.
REQ-016 A granted in-range, aligned access SHALL drive mem_req=1 in the grant cycle, with mem_addr=addr[log2(SIZE)-1:2].
REQ-017 The response SHALL appear exactly one cycle after the grant: resp=RDY_OK, with rdata valid in that cycle only; the port shows NOTRDY in all other cycles.
REQ-018 Back-to-back grants to the same port every cycle SHALL be supported (full throughput, no bubble).
REQ-019 dmem write: mem_wen=1; BYTE -> wdata replicated x4, byteen=1<<addr[1:0]; HWORD -> replicated x2, byteen=2'b11<<{addr[1],0}; WORD -> byteen=4'b1111.
REQ-020 Read data returned = mem_rdata >> (8*registered addr[1:0]), with the offset captured at grant.
REQ-021 addr >= SCR1_TCM_SIZE, HWORD with addr[0]=1, or WORD with addr[1:0]!=0 -> still acked; mem_req=0; RDY_ER next cycle; rdata=0; no write.
REQ-022 imem accesses are always reads; misalignment is checked only on addr[1:0]!=0.
REQ-023 A losing requester SHALL NOT be acked and holds its request; it is guaranteed a grant within 2 cycles.

Reset
REQ-024 While rst=1: imem_resp=dmem_resp=NOTRDY; acks follow the combinational grant, but mem_req=mem_wen=0.
REQ-025 Reset SHALL set last_gnt=IMEM (dmem wins the first conflict), clear the offset/error registers, and set rdata=0.
REQ-026 Reset asserted mid-transaction SHALL discard the pending response; no RDY_OK follows reset release.

Structure
REQ-027 type_scr1_mem_cmd_e, type_scr1_mem_width_e and type_scr1_mem_resp_e SHALL come from the shared memif package; no local redefinition.
REQ-028 The two-way round-robin grant SHALL be one sub-module, scr1_rr_arb2 (req[1:0], gnt[1:0], last-grant register).
REQ-029 The SRAM SHALL stay external; this block contains no storage array.

Verification
REQ-030 imem_req alone, addr 0x100, mem_rdata=0xDEADBEEF -> ack in cycle N, imem_resp=RDY_OK and imem_rdata=0xDEADBEEF in cycle N+1.
REQ-031 Both ports request continuously after reset -> grants alternate D,I,D,I; each port gets one RDY_OK every 2 cycles.
REQ-032 dmem BYTE write 0xA5 to addr 0x7 -> mem_wdata=0xA5A5A5A5, mem_byteen=4'b1000, mem_wen=1 in the grant cycle.
REQ-033 dmem HWORD read addr 0x2, mem_rdata=0x12345678 -> dmem_rdata=0x00001234 and RDY_OK.
REQ-034 dmem WORD write to addr 0x10001 (out of range and misaligned) -> acked, mem_req=0, RDY_ER next cycle.
REQ-035 rst pulsed in the cycle after a grant -> resp=NOTRDY during and after reset; the next conflict is granted to dmem.
